pwm_axil_ramp_sequencer: RTL
============================

# pwm_axil_ramp_sequencer

AXI4-Lite master that programs and sequences the PWMAXI register block: writes the period, enables the channel, then ramps the duty register from a start value to an end value in fixed steps at a programmable interval. It sits between local control logic and the PWMAXI S00_AXI slave port, replacing software register pokes for smooth brightness and motor ramps.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported
- BASE_ADDR, 32'h0000_0000, PWMAXI base address
- CTRL_OFFSET, 4'h0, control register; bit0 = enable
- PERIOD_OFFSET, 4'h4, period register
- DUTY_OFFSET, 4'h8, duty register
- ACLK  in  1  clock; all logic rising-edge
- ARESET  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a ramp
- stop  in  1  one-cycle pulse; aborts a ramp
- cfg_period  in  32  period value, sampled on start
- cfg_duty_start / cfg_duty_end  in  32 each  ramp endpoints, sampled on start
- cfg_step  in  32  duty increment magnitude, sampled on start
- cfg_interval  in  16  idle cycles between duty writes, sampled on start
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE
- error  out  1  sticky; cleared by next accepted start
- cur_duty  out  32  last duty value whose write received BVALID
- M_AXI_AW{ADDR,PROT,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,PROT,VALID,READY}, M_AXI_R{DATA,RESP,VALID,READY}  standard AXI4-Lite master; PROT = 3'b000, WSTRB = 4'hF

## Operation
- States: IDLE, WR_PERIOD, WR_EN, WR_DUTY, RD_DUTY, CHK, WAIT, WR_DIS.
- IDLE: start accepted -> latch cfg, clear error, cur target = cfg_duty_start, go WR_PERIOD. start while busy ignored.
- WR_PERIOD -> WR_EN (CTRL=1) -> WR_DUTY(target).
- Write transaction: AWVALID and WVALID raised together; each dropped independently on its READY; BREADY high while awaiting B; state advances on BVALID.
- After WR_DUTY: RD_DUTY/CHK (see Configuration), else WAIT.
- WAIT: count cfg_interval cycles (0 = skip). If target == cfg_duty_end -> WR_DIS path skipped, go IDLE with done; channel stays enabled. Otherwise compute next target, go WR_DUTY.
- Step: ascending (end >= start) next = min(cur+step, end); descending next = max(cur-step, end), computed in 33 bits, no wrap. cfg_step = 0 -> next = end.
- stop: latched; current AXI transaction always completes (no handshake abandoned); then WR_DIS (CTRL=0) -> IDLE, done pulses.
- BRESP or RRESP != OKAY: set error, go WR_DIS -> IDLE. Error on the WR_DIS write itself: set error, go IDLE.
- start and stop same cycle in IDLE: stop wins, start ignored.

## Timing
- Reset: all VALIDs, BREADY, RREADY, busy, done, error = 0; cur_duty = 0; state IDLE. Reset mid-transaction drops VALIDs immediately (asynchronous).
- AWVALID/WVALID/ARVALID assert the cycle after state entry; with zero-wait slave a write occupies 3 cycles (valid, B, advance).
- busy rises the cycle after start; done pulses the cycle state returns to IDLE, same cycle busy falls.
- cur_duty updates the cycle after BVALID&&BREADY of a duty write.

## Configuration
- PWM_RAMP_READBACK_EN defined: after each WR_DUTY, read DUTY_OFFSET (ARVALID until ARREADY, RREADY until RVALID); CHK compares RDATA to target; mismatch sets error and aborts via WR_DIS.
- Undefined: RD_DUTY/CHK absent, AR/R outputs tied to 0, WR_DUTY goes directly to WAIT.

## Test plan
- start, period=1000, start=0, end=100, step=25, interval=4 -> writes 0x4=1000, 0x0=1, 0x8=0,25,50,75,100; done once; cur_duty=100; error=0.
- Descending start=100, end=10, step=40 -> duty writes 100,60,20,10; no underflow.
- stop during third duty write with slave WREADY delayed 5 cycles -> write completes, then 0x0=0, done, busy low.
- Slave returns BRESP=SLVERR on period write -> error=1, CTRL=0 written, IDLE.
- With PWM_RAMP_READBACK_EN, slave returns RDATA off by one -> error=1, abort after first duty.
- ARESET asserted mid-WAIT then released; start again -> full sequence repeats from WR_PERIOD.

Source files
------------

// File: rtl/pwm_axil_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_axil_ramp_sequencer
//
// AXI4-Lite master that programs a PWMAXI register block. On a start pulse it
// writes the period and sets the enable bit. It then writes the duty register,
// stepping from a start value to an end value, and waits a programmable number
// of idle cycles between duty writes. A stop pulse lets the AXI transaction in
// flight finish, clears the enable bit and returns to idle. A non-OKAY response
// also clears the enable bit and returns to idle.
//
// Optional feature macro: PWM_RAMP_READBACK_EN
//   When defined, each duty write is followed by a read of the duty register.
//   A readback that does not match the written value sets error and aborts.
//   When undefined, the AR/R channel outputs are tied to zero.
//
// Ports
//   ACLK, ARESET             clock (rising edge) and async active-high reset
//   start / stop             one-cycle command pulses
//   cfg_period               period value, sampled on an accepted start
//   cfg_duty_start/_end      ramp endpoints, sampled on an accepted start
//   cfg_step                 duty step magnitude (0 = jump straight to end)
//   cfg_interval             idle cycles between duty writes
//   busy                     high while a sequence is running
//   done                     one-cycle pulse on return to idle
//   error                    sticky error flag, cleared by the next start
//   cur_duty                 last duty value whose write was acknowledged
//   M_AXI_*                  AXI4-Lite master port
// -----------------------------------------------------------------------------
module pwm_axil_ramp_sequencer #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [3:0] CTRL_OFFSET   = 4'h0,
    parameter logic [3:0] PERIOD_OFFSET = 4'h4,
    parameter logic [3:0] DUTY_OFFSET   = 4'h8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            start,
    input  logic                            stop,
    input  logic [31:0]                     cfg_period,
    input  logic [31:0]                     cfg_duty_start,
    input  logic [31:0]                     cfg_duty_end,
    input  logic [31:0]                     cfg_step,
    input  logic [15:0]                     cfg_interval,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [31:0]                     cur_duty,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_PERIOD = 3'd1,
        ST_WR_EN     = 3'd2,
        ST_WR_DUTY   = 3'd3,
`ifdef PWM_RAMP_READBACK_EN
        ST_RD_DUTY   = 3'd4,
        ST_CHK       = 3'd5,
`endif
        ST_WAIT      = 3'd6,
        ST_WR_DIS    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        issued_q, issued_d;      // request of the current state already raised
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        stop_q, stop_d;          // stop seen, acted on at the next safe point
    logic        asc_q, asc_d;            // ramp direction: end >= start
    logic [31:0] period_q, period_d;
    logic [31:0] end_q, end_d;
    logic [31:0] step_q, step_d;
    logic [15:0] interval_q, interval_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] cur_duty_q, cur_duty_d;
    logic [31:0] next_target;
`ifdef PWM_RAMP_READBACK_EN
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic [31:0] rdata_q, rdata_d;
`endif

    // Next duty target: widened to 33 bits so a large step clamps at the end
    // value instead of wrapping past it in either direction.
    logic [32:0] sum_w, diff_w;
    always_comb begin
        sum_w  = {1'b0, target_q} + {1'b0, step_q};
        diff_w = {1'b0, target_q} - {1'b0, step_q};
        next_target = end_q;
        if (step_q != 32'd0) begin
            if (asc_q) begin
                if (sum_w < {1'b0, end_q}) next_target = sum_w[31:0];
            end else begin
                if (!diff_w[32] && (diff_w[31:0] > end_q)) next_target = diff_w[31:0];
            end
        end
    end

    logic is_wr, wr_done, wr_err, stop_pend;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        issued_d   = issued_q;
        done_d     = 1'b0;
        error_d    = error_q;
        stop_d     = stop_q | (stop && (state_q != ST_IDLE));
        asc_d      = asc_q;
        period_d   = period_q;
        end_d      = end_q;
        step_d     = step_q;
        interval_d = interval_q;
        wait_cnt_d = wait_cnt_q;
        target_d   = target_q;
        cur_duty_d = cur_duty_q;
`ifdef PWM_RAMP_READBACK_EN
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        rdata_d    = rdata_q;
`endif
        stop_pend  = stop_q | stop;
        wr_err     = (M_AXI_BRESP != 2'b00);
        wr_done    = 1'b0;

        // Shared write handshake: AW and W go up together one cycle after
        // state entry, each drops on its own READY, the state advances on B.
        is_wr = (state_q == ST_WR_PERIOD) || (state_q == ST_WR_EN) ||
                (state_q == ST_WR_DUTY)   || (state_q == ST_WR_DIS);
        if (is_wr) begin
            if (!issued_q) begin
                aw_valid_d = 1'b1;
                w_valid_d  = 1'b1;
                b_ready_d  = 1'b1;
                issued_d   = 1'b1;
            end else begin
                if (aw_valid_q && M_AXI_AWREADY) aw_valid_d = 1'b0;
                if (w_valid_q && M_AXI_WREADY)   w_valid_d  = 1'b0;
                if (b_ready_q && M_AXI_BVALID) begin
                    b_ready_d = 1'b0;
                    issued_d  = 1'b0;
                    wr_done   = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A simultaneous stop wins over start.
                if (start && !stop) begin
                    period_d   = cfg_period;
                    end_d      = cfg_duty_end;
                    step_d     = cfg_step;
                    interval_d = cfg_interval;
                    target_d   = cfg_duty_start;
                    asc_d      = (cfg_duty_end >= cfg_duty_start);
                    error_d    = 1'b0;
                    state_d    = ST_WR_PERIOD;
                end
            end
            ST_WR_PERIOD: begin
                if (wr_done) begin
                    if (wr_err)         begin error_d = 1'b1; state_d = ST_WR_DIS; end
                    else if (stop_pend) state_d = ST_WR_DIS;
                    else                state_d = ST_WR_EN;
                end
            end
            ST_WR_EN: begin
                if (wr_done) begin
                    if (wr_err)         begin error_d = 1'b1; state_d = ST_WR_DIS; end
                    else if (stop_pend) state_d = ST_WR_DIS;
                    else                state_d = ST_WR_DUTY;
                end
            end
            ST_WR_DUTY: begin
                if (wr_done) begin
                    cur_duty_d = target_q;
                    wait_cnt_d = 16'd0;
                    if (wr_err)         begin error_d = 1'b1; state_d = ST_WR_DIS; end
                    else if (stop_pend) state_d = ST_WR_DIS;
`ifdef PWM_RAMP_READBACK_EN
                    else                state_d = ST_RD_DUTY;
`else
                    else                state_d = ST_WAIT;
`endif
                end
            end
`ifdef PWM_RAMP_READBACK_EN
            ST_RD_DUTY: begin
                if (!issued_q) begin
                    ar_valid_d = 1'b1;
                    r_ready_d  = 1'b1;
                    issued_d   = 1'b1;
                end else begin
                    if (ar_valid_q && M_AXI_ARREADY) ar_valid_d = 1'b0;
                    if (r_ready_q && M_AXI_RVALID) begin
                        r_ready_d = 1'b0;
                        issued_d  = 1'b0;
                        rdata_d   = M_AXI_RDATA;
                        if (M_AXI_RRESP != 2'b00) begin error_d = 1'b1; state_d = ST_WR_DIS; end
                        else                      state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                wait_cnt_d = 16'd0;
                if (rdata_q != target_q) begin error_d = 1'b1; state_d = ST_WR_DIS; end
                else if (stop_pend)      state_d = ST_WR_DIS;
                else                     state_d = ST_WAIT;
            end
`endif
            ST_WAIT: begin
                if (stop_pend) begin
                    state_d = ST_WR_DIS;
                end else if (wait_cnt_q == interval_q) begin
                    // A finished ramp leaves the channel enabled.
                    if (target_q == end_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        target_d = next_target;
                        state_d  = ST_WR_DUTY;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_WR_DIS: begin
                if (wr_done) begin
                    if (wr_err) error_d = 1'b1;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) stop_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            issued_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            stop_q     <= 1'b0;
            asc_q      <= 1'b0;
            period_q   <= '0;
            end_q      <= '0;
            step_q     <= '0;
            interval_q <= '0;
            wait_cnt_q <= '0;
            target_q   <= '0;
            cur_duty_q <= '0;
        end else begin
            state_q    <= state_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            error_q    <= error_d;
            stop_q     <= stop_d;
            asc_q      <= asc_d;
            period_q   <= period_d;
            end_q      <= end_d;
            step_q     <= step_d;
            interval_q <= interval_d;
            wait_cnt_q <= wait_cnt_d;
            target_q   <= target_d;
            cur_duty_q <= cur_duty_d;
        end
    end

    // Address/data follow the state, which is stable for the whole transaction.
    logic [3:0]                    wr_off;
    logic [C_M_AXI_ADDR_WIDTH-1:0] wr_off_ext;
    logic [31:0]                   wr_data;
    always_comb begin
        wr_off  = DUTY_OFFSET;
        wr_data = target_q;
        case (state_q)
            ST_WR_PERIOD: begin wr_off = PERIOD_OFFSET; wr_data = period_q; end
            ST_WR_EN:     begin wr_off = CTRL_OFFSET;   wr_data = 32'd1;    end
            ST_WR_DIS:    begin wr_off = CTRL_OFFSET;   wr_data = 32'd0;    end
            default:      ;
        endcase
        wr_off_ext      = '0;
        wr_off_ext[3:0] = wr_off;
    end

    assign M_AXI_AWADDR  = BASE_ADDR + wr_off_ext;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_valid_q;
    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_valid_q;
    assign M_AXI_BREADY  = b_ready_q;

`ifdef PWM_RAMP_READBACK_EN
    logic [C_M_AXI_ADDR_WIDTH-1:0] rd_off_ext;
    always_comb begin
        rd_off_ext      = '0;
        rd_off_ext[3:0] = DUTY_OFFSET;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign M_AXI_ARADDR  = BASE_ADDR + rd_off_ext;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = ar_valid_q;
    assign M_AXI_RREADY  = r_ready_q;
`else
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;

    // Read channel inputs have no function without readback.
    logic unused_rd_inputs;
    assign unused_rd_inputs = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign cur_duty = cur_duty_q;

endmodule
